// File: rtl/z80_int_ctrl_pkg.sv
// Shared Z80 interrupt definitions: RST opcode constants and the vector builder.
// Also used by the sound CPU wrapper.
package z80_int_ctrl_pkg;

  typedef logic [7:0] byte_t;

  // RST 00h opcode; the restart address sits in bits [5:3]
  localparam byte_t RST_BASE = 8'hC7;
  // RST 38h, used as the spurious-ack vector
  localparam byte_t RST38    = 8'hFF;
  // Upper bound on source count: the vector can only encode 8 restart slots
  localparam int    MAX_SRC  = 8;

  // RST opcode servicing source idx (jumps to idx*8)
  function automatic byte_t rst_opcode(input logic [2:0] idx);
    return RST_BASE | {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/z80_int_ctrl_if.sv
// CPU-side bus bundle between the Z80 core and the interrupt controller.
interface z80_int_ctrl_if;
  logic       m1_n;
  logic       iorq_n;
  logic       wr_n;
  logic [7:0] A;
  logic [7:0] cpu_dout;
  logic       int_n;
  logic [7:0] vec;
  logic       vec_oe;

  // CPU side: drives strobes/address/data, receives the request and vector
  modport master (
    output m1_n, iorq_n, wr_n, A, cpu_dout,
    input  int_n, vec, vec_oe
  );

  // Controller side
  modport slave (
    input  m1_n, iorq_n, wr_n, A, cpu_dout,
    output int_n, vec, vec_oe
  );
endinterface

// File: rtl/z80_int_prio.sv
// Lowest-index-first priority encoder over the pending request bits.
module z80_int_prio #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic [2:0]      idx,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx = 3'd0;
    any = |req;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 maskable interrupt controller: edge-latched sources, CPU-writable
// enable mask, fixed priority, RST-opcode vector during the ack cycle.
module z80_int_ctrl
  import z80_int_ctrl_pkg::*;
#(
  parameter int    NSRC      = 4,
  parameter byte_t MASK_PORT = 8'h00,
  parameter byte_t SPUR_VEC  = RST38
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src_i,
  z80_int_ctrl_if.slave   bus,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  // Registered state
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] mask_reg;
  logic            ack_q;
  logic            wr_q;
  logic            int_n_reg;
  byte_t           vec_reg;

  // Combinational event terms
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] mask_next;
  logic [NSRC-1:0] pending_next;
  logic            ack;
  logic            ack_start;
  logic            wr_cond;
  logic            wr_start;
  logic            mask_wr;
  logic [2:0]      prio_idx;
  logic            prio_any;
  logic            unused_dout_bits;

  // Only the low NSRC data bits carry mask information
  assign unused_dout_bits = ^bus.cpu_dout;

  assign ack       = ~bus.m1_n & ~bus.iorq_n;
  assign ack_start = ack & ~ack_q;
  assign wr_cond   = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;
  assign wr_start  = wr_cond & ~wr_q;
  assign mask_wr   = wr_start && (bus.A == MASK_PORT);
  assign mask_next = mask_wr ? bus.cpu_dout[NSRC-1:0] : mask_reg;

  // Rise uses the mask as it stands before this edge; a write landing on the
  // same edge then clears through mask_next, so mask clearing wins.
  assign rise = src_i & ~src_q & mask_reg;

  z80_int_prio #(
    .NSRC (NSRC)
  ) u_prio (
    .req (pending_reg),
    .idx (prio_idx),
    .any (prio_any)
  );

  // One-hot clear of the source being acknowledged
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ack_clr
      assign ack_clr[gi] = ack_start & prio_any & (prio_idx == 3'(gi));
    end
  endgenerate

  // Ack clear first, rise re-sets (set wins), mask write clears last
  always_comb begin
    pending_next = (pending_reg & ~ack_clr) | rise;
    if (mask_wr) pending_next = pending_next & mask_next;
  end

  // Edge history, bus cycle trackers, mask and pending state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= '0;
      ack_q       <= 1'b0;
      wr_q        <= 1'b0;
      mask_reg    <= '0;
      pending_reg <= '0;
      int_n_reg   <= 1'b1;
    end else begin
      src_q       <= src_i;
      ack_q       <= ack;
      wr_q        <= wr_cond;
      mask_reg    <= mask_next;
      pending_reg <= pending_next;
      int_n_reg   <= ~|pending_next;
    end
  end

  // Vector byte latched once at the start of each ack cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_reg <= SPUR_VEC;
    end else if (ack_start) begin
      vec_reg <= prio_any ? rst_opcode(prio_idx) : SPUR_VEC;
    end
  end

  assign bus.int_n  = int_n_reg;
  assign bus.vec    = vec_reg;
  assign bus.vec_oe = ack_q;
  assign pending    = pending_reg;
  assign mask       = mask_reg;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl (NSRC=4, mask port 00h, spurious vector FFh).
module tb_z80_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] src_i = 4'h0;
  logic [3:0] pending;
  logic [3:0] mask;
  int         n_cmp = 0;
  int         n_err = 0;

  z80_int_ctrl_if bus ();

  z80_int_ctrl #(
    .NSRC      (4),
    .MASK_PORT (8'h00),
    .SPUR_VEC  (8'hFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .src_i   (src_i),
    .bus     (bus),
    .pending (pending),
    .mask    (mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    step();
  endtask

  task automatic io_begin(input logic [7:0] port, input logic [7:0] data);
    bus.A = port; bus.cpu_dout = data;
    bus.m1_n = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    step();
  endtask

  task automatic ack_begin();
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0; bus.wr_n = 1'b1;
    step();
  endtask

  initial begin
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    bus.A = 8'h00; bus.cpu_dout = 8'h00;
    step(); step();
    // reset state
    chk("rst_pending", {4'h0, pending}, 8'h00);
    chk("rst_mask",    {4'h0, mask},    8'h00);
    chk("rst_int_n",   {7'h0, bus.int_n},  8'h01);
    chk("rst_vec",     bus.vec,            8'hFF);
    chk("rst_vec_oe",  {7'h0, bus.vec_oe}, 8'h00);
    reset_n = 1'b1;
    step();

    // 1: masked source is ignored
    src_i = 4'h1; step();
    chk("t1_pending", {4'h0, pending}, 8'h00);
    chk("t1_int_n",   {7'h0, bus.int_n}, 8'h01);
    src_i = 4'h0; step();

    // 2: enable all, single source, ack
    io_begin(8'h00, 8'h0F);
    chk("t2_mask", {4'h0, mask}, 8'h0F);
    bus_idle();
    src_i = 4'h4; step();
    chk("t2_pending", {4'h0, pending}, 8'h04);
    chk("t2_int_n",   {7'h0, bus.int_n}, 8'h00);
    ack_begin();
    chk("t2_vec",     bus.vec, 8'hD7);
    chk("t2_vec_oe",  {7'h0, bus.vec_oe}, 8'h01);
    chk("t2_pend_ack",{4'h0, pending}, 8'h00);
    chk("t2_int_ack", {7'h0, bus.int_n}, 8'h01);
    step();
    chk("t2_vec_oe_held", {7'h0, bus.vec_oe}, 8'h01);
    bus_idle();
    chk("t2_vec_oe_drop", {7'h0, bus.vec_oe}, 8'h00);
    src_i = 4'h0; step();

    // 3: two simultaneous sources, serviced in priority order; held level re-requests nothing
    src_i = 4'hA; step();
    chk("t3_pending", {4'h0, pending}, 8'h0A);
    ack_begin();
    chk("t3_vec1",  bus.vec, 8'hCF);
    chk("t3_int1",  {7'h0, bus.int_n}, 8'h00);
    chk("t3_pend1", {4'h0, pending}, 8'h08);
    bus_idle();
    ack_begin();
    chk("t3_vec2",  bus.vec, 8'hDF);
    chk("t3_pend2", {4'h0, pending}, 8'h00);
    chk("t3_int2",  {7'h0, bus.int_n}, 8'h01);
    bus_idle();
    chk("t3_held_level", {4'h0, pending}, 8'h00);
    src_i = 4'h0; step();

    // 4: spurious ack
    ack_begin();
    chk("t4_vec",     bus.vec, 8'hFF);
    chk("t4_vec_oe",  {7'h0, bus.vec_oe}, 8'h01);
    chk("t4_pending", {4'h0, pending}, 8'h00);
    chk("t4_mask",    {4'h0, mask}, 8'h0F);
    chk("t4_int_n",   {7'h0, bus.int_n}, 8'h01);
    bus_idle();

    // 5: mask write clears a pending bit; other port ignored
    src_i = 4'h4; step();
    chk("t5_pending", {4'h0, pending}, 8'h04);
    io_begin(8'h00, 8'h0B);
    chk("t5_mask",     {4'h0, mask}, 8'h0B);
    chk("t5_pend_clr", {4'h0, pending}, 8'h00);
    chk("t5_int_n",    {7'h0, bus.int_n}, 8'h01);
    bus_idle();
    io_begin(8'h01, 8'h00);
    chk("t5_other_port", {4'h0, mask}, 8'h0B);
    bus_idle();
    // mask clear beats a same-edge rise; an enabled source's rise still latches
    io_begin(8'h00, 8'h0F);
    bus_idle();
    src_i = 4'h0; step();
    bus.A = 8'h00; bus.cpu_dout = 8'h0B;
    bus.m1_n = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    src_i = 4'h5;
    step();
    chk("t5_clr_vs_rise", {4'h0, pending}, 8'h01);
    chk("t5_clr_int_n",   {7'h0, bus.int_n}, 8'h00);
    bus_idle();
    ack_begin();
    chk("t5_vec0", bus.vec, 8'hC7);
    chk("t5_pend_after", {4'h0, pending}, 8'h00);
    bus_idle();
    src_i = 4'h0; step();

    // 6: rise on the ack edge that clears the same source -> stays pending
    src_i = 4'h1; step();
    chk("t6_pending", {4'h0, pending}, 8'h01);
    src_i = 4'h0; step();
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0; bus.wr_n = 1'b1;
    src_i = 4'h1;
    step();
    chk("t6_vec",       bus.vec, 8'hC7);
    chk("t6_set_wins",  {4'h0, pending}, 8'h01);
    chk("t6_int_n",     {7'h0, bus.int_n}, 8'h00);
    src_i = 4'h3; step();
    chk("t6_rise1", {4'h0, pending}, 8'h03);
    bus_idle();
    ack_begin();
    chk("t6_vec2",  bus.vec, 8'hC7);
    chk("t6_pend2", {4'h0, pending}, 8'h02);
    chk("t6_oe2",   {7'h0, bus.vec_oe}, 8'h01);
    // asynchronous reset in the middle of the ack
    reset_n = 1'b0;
    #1;
    chk("t6_rst_vec_oe",  {7'h0, bus.vec_oe}, 8'h00);
    chk("t6_rst_int_n",   {7'h0, bus.int_n}, 8'h01);
    chk("t6_rst_pending", {4'h0, pending}, 8'h00);
    chk("t6_rst_mask",    {4'h0, mask}, 8'h00);
    chk("t6_rst_vec",     bus.vec, 8'hFF);
    src_i = 4'h0;
    bus_idle();
    step();
    reset_n = 1'b1;
    step();
    chk("t6_post_rst_int_n", {7'h0, bus.int_n}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
